tcam_access_ctrl: RTL

//  Sequences and shares the 28-bit-key / 64-entry TCAM macro between two requesters: a config write port and a search port.

---
 rtl/tcam_ctrl_pkg.sv | 24 ++
 rtl/tcam_rr_arb2.sv | 28 ++
 rtl/tcam_access_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/tcam_ctrl_pkg.sv
// Shared widths, FSM encoding and helpers for the TCAM access controller.
package tcam_ctrl_pkg;

  localparam int TCAM_KEY_W   = 28;
  localparam int TCAM_WADDR_W = 10;
  localparam int TCAM_DATA_W  = 32;
  localparam int TCAM_MASK_W  = 4;
  localparam int TCAM_PMA_W   = 6;
  localparam int STAT_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_SEARCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } tcam_ctrl_state_e;

  // Saturating increment used by the optional statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tcam_rr_arb2.sv
// Two-way round-robin arbiter: req[0] is the write port, req[1] the search port.
module tcam_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic prefer_search;

  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || !prefer_search))
      grant = 2'b01;
    else if (req[1])
      grant = 2'b10;
  end

  // After serving one side, the other side wins the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prefer_search <= 1'b0;
    else if (accept)
      prefer_search <= grant[0];
  end

endmodule

// File: rtl/tcam_access_ctrl.sv
// Shares one TCAM macro between a config write port and a search port.
// Optional access counters are built when TCAM_CTRL_STATS_EN is defined.
module tcam_access_ctrl
  import tcam_ctrl_pkg::*;
#(
  parameter int SEARCH_LAT = 1
) (
  input  logic                    in_clk,
  input  logic                    in_rst_n,
  input  logic                    in_wr_valid,
  output logic                    out_wr_ready,
  input  logic [TCAM_WADDR_W-1:0] in_wr_addr,
  input  logic [TCAM_DATA_W-1:0]  in_wr_wdata,
  input  logic [TCAM_MASK_W-1:0]  in_wr_wmask,
  input  logic                    in_sr_valid,
  output logic                    out_sr_ready,
  input  logic [TCAM_KEY_W-1:0]   in_sr_key,
  output logic                    out_rsp_valid,
  input  logic                    in_rsp_ready,
  output logic [TCAM_PMA_W-1:0]   out_rsp_pma,
  output logic                    out_tcam_csb,
  output logic                    out_tcam_web,
  output logic [TCAM_MASK_W-1:0]  out_tcam_wmask,
  output logic [TCAM_KEY_W-1:0]   out_tcam_addr,
  output logic [TCAM_DATA_W-1:0]  out_tcam_wdata,
  input  logic [TCAM_PMA_W-1:0]   in_tcam_pma,
  output logic                    out_busy
`ifdef TCAM_CTRL_STATS_EN
  ,
  input  logic                    in_stat_clr,
  output logic [STAT_W-1:0]       out_stat_writes,
  output logic [STAT_W-1:0]       out_stat_searches
`endif
);

  localparam logic [2:0] LAT_INIT = 3'(SEARCH_LAT);

  tcam_ctrl_state_e state;
  logic [2:0]       lat_cnt;
  logic [1:0]       grant;
  logic             wr_acc;
  logic             sr_acc;

  tcam_rr_arb2 u_arb (
    .clk    (in_clk),
    .rst_n  (in_rst_n),
    .req    ({in_sr_valid, in_wr_valid}),
    .accept (wr_acc | sr_acc),
    .grant  (grant)
  );

  // Readies are masked by reset so nothing handshakes while the block is held.
  assign out_wr_ready = in_rst_n & (state == ST_IDLE) & grant[0];
  assign out_sr_ready = in_rst_n & (state == ST_IDLE) & grant[1];
  assign wr_acc       = in_wr_valid & out_wr_ready;
  assign sr_acc       = in_sr_valid & out_sr_ready;
  assign out_busy     = (state != ST_IDLE);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state          <= ST_IDLE;
      lat_cnt        <= '0;
      out_tcam_csb   <= 1'b1;
      out_tcam_web   <= 1'b1;
      out_tcam_wmask <= '0;
      out_tcam_addr  <= '0;
      out_tcam_wdata <= '0;
      out_rsp_valid  <= 1'b0;
      out_rsp_pma    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_acc) begin
            state          <= ST_WRITE;
            out_tcam_csb   <= 1'b0;
            out_tcam_web   <= 1'b0;
            out_tcam_wmask <= in_wr_wmask;
            out_tcam_addr  <= {{(TCAM_KEY_W-TCAM_WADDR_W){1'b0}}, in_wr_addr};
            out_tcam_wdata <= in_wr_wdata;
          end else if (sr_acc) begin
            state          <= ST_SEARCH;
            out_tcam_csb   <= 1'b0;
            out_tcam_web   <= 1'b1;
            out_tcam_wmask <= '0;
            out_tcam_addr  <= in_sr_key;
            out_tcam_wdata <= '0;
          end
        end
        ST_WRITE: begin
          state          <= ST_IDLE;
          out_tcam_csb   <= 1'b1;
          out_tcam_web   <= 1'b1;
          out_tcam_wmask <= '0;
        end
        ST_SEARCH: begin
          out_tcam_csb <= 1'b1;
          out_tcam_web <= 1'b1;
          if (SEARCH_LAT == 0) begin
            out_rsp_pma   <= in_tcam_pma;
            out_rsp_valid <= 1'b1;
            state         <= ST_RESP;
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == 3'd1) begin
            out_rsp_pma   <= in_tcam_pma;
            out_rsp_valid <= 1'b1;
            state         <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        ST_RESP: begin
          if (in_rsp_ready) begin
            out_rsp_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef TCAM_CTRL_STATS_EN
  logic [STAT_W-1:0] writes_cnt;
  logic [STAT_W-1:0] searches_cnt;

  // Clear has priority over a same-cycle accept.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      writes_cnt   <= '0;
      searches_cnt <= '0;
    end else if (in_stat_clr) begin
      writes_cnt   <= '0;
      searches_cnt <= '0;
    end else begin
      if (wr_acc) writes_cnt   <= sat_inc(writes_cnt);
      if (sr_acc) searches_cnt <= sat_inc(searches_cnt);
    end
  end

  assign out_stat_writes   = writes_cnt;
  assign out_stat_searches = searches_cnt;
`endif

endmodule
